mem_loader: RTL

Program loader that writes the regex instruction memory. It accepts a framed byte stream over a valid/ready handshake, packs the bytes into DATA_BITS-wide words and writes them to consecutive memory addresses from 0 through the memory write port (w_en/w_addr/w_data). It checks the frame length and an 8-bit checksum, then flags whether the stored program is valid for the matching engine.

---
 rtl/mem_loader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// Loads the regex instruction memory from a framed byte stream.
// Frame: LEN_HI, LEN_LO, N big-endian words, checksum byte; reports done/error.
//
// state  | meaning
// LEN_HI | idle, waiting for the high length byte
// LEN_LO | waiting for the low length byte
// DATA   | packing data bytes into words and writing them out
// CHECK  | waiting for the checksum byte
// REPORT | one-cycle done/error report, in_ready low
module mem_loader #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 w_en,
  output logic [ADDR_BITS-1:0] w_addr,
  output logic [DATA_BITS-1:0] w_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic                 prog_valid,
  output logic [ADDR_BITS:0]   words_loaded
);

  localparam int BYTES     = DATA_BITS / 8;
  localparam int CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int MAX_WORDS = 2 ** ADDR_BITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_REPORT
  } state_t;

  state_t                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   w_en_q, w_en_d;
  logic [ADDR_BITS-1:0]   w_addr_q, w_addr_d;
  logic [DATA_BITS-1:0]   w_data_q, w_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   prog_valid_q, prog_valid_d;
  logic [ADDR_BITS:0]     words_loaded_q, words_loaded_d;
  logic [ADDR_BITS:0]     n_q, n_d;
  logic [7:0]             len_hi_q, len_hi_d;
  logic [7:0]             sum_q, sum_d;
  logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [DATA_BITS-1:0]   word_q, word_d;

  logic                   accept;
  logic [15:0]            len_full;
  logic [DATA_BITS-1:0]   word_nxt;
  logic [ADDR_BITS:0]     words_inc;
  logic [7:0]             sum_nxt;

  always_comb begin
    state_d        = state_q;
    w_en_d         = 1'b0;
    w_addr_d       = w_addr_q;
    w_data_d       = w_data_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    error_d        = 1'b0;
    err_code_d     = err_code_q;
    prog_valid_d   = prog_valid_q;
    words_loaded_d = words_loaded_q;
    n_d            = n_q;
    len_hi_d       = len_hi_q;
    sum_d          = sum_q;
    byte_cnt_d     = byte_cnt_q;
    word_d         = word_q;

    accept    = in_valid && in_ready_q;
    len_full  = {len_hi_q, in_data};
    word_nxt  = DATA_BITS'({word_q, in_data});
    words_inc = words_loaded_q + (ADDR_BITS+1)'(1);
    sum_nxt   = sum_q + in_data;

    case (state_q)
      S_LEN_HI: if (accept) begin
        prog_valid_d   = 1'b0;
        err_code_d     = 2'b00;
        words_loaded_d = '0;
        sum_d          = in_data;
        len_hi_d       = in_data;
        byte_cnt_d     = '0;
        busy_d         = 1'b1;
        state_d        = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        sum_d = sum_nxt;
        n_d   = len_full[ADDR_BITS:0];
        if ({16'd0, len_full} > 32'(MAX_WORDS)) begin
          err_code_d = 2'b01;
          error_d    = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_REPORT;
        end else if (len_full == 16'd0) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (accept) begin
        sum_d  = sum_nxt;
        word_d = word_nxt;
        if (byte_cnt_q == CNT_LAST) begin
          byte_cnt_d     = '0;
          w_en_d         = 1'b1;
          w_addr_d       = words_loaded_q[ADDR_BITS-1:0];
          w_data_d       = word_nxt;
          words_loaded_d = words_inc;
          if (words_inc == n_q) state_d = S_CHECK;
        end else begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: if (accept) begin
        sum_d   = sum_nxt;
        busy_d  = 1'b0;
        state_d = S_REPORT;
        // done/error are registered so they land in the REPORT cycle itself
        if (sum_nxt != 8'h00) begin
          err_code_d = 2'b10;
          error_d    = 1'b1;
        end else begin
          done_d       = 1'b1;
          prog_valid_d = 1'b1;
        end
      end
      S_REPORT: state_d = S_LEN_HI;
      default:  state_d = S_LEN_HI;
    endcase

    in_ready_d = (state_d != S_REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_LEN_HI;
      in_ready_q     <= 1'b0;
      w_en_q         <= 1'b0;
      w_addr_q       <= '0;
      w_data_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= 2'b00;
      prog_valid_q   <= 1'b0;
      words_loaded_q <= '0;
      n_q            <= '0;
      len_hi_q       <= '0;
      sum_q          <= '0;
      byte_cnt_q     <= '0;
      word_q         <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      w_en_q         <= w_en_d;
      w_addr_q       <= w_addr_d;
      w_data_q       <= w_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
      prog_valid_q   <= prog_valid_d;
      words_loaded_q <= words_loaded_d;
      n_q            <= n_d;
      len_hi_q       <= len_hi_d;
      sum_q          <= sum_d;
      byte_cnt_q     <= byte_cnt_d;
      word_q         <= word_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign w_en         = w_en_q;
  assign w_addr       = w_addr_q;
  assign w_data       = w_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign prog_valid   = prog_valid_q;
  assign words_loaded = words_loaded_q;

endmodule
